// File: rtl/alu2_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu2_issue_queue_pkg
// Purpose : Op codes, FSM states and command packing for the ALU2 issue queue
// Rev     : 1.0  initial release
// ============================================================================
package alu2_issue_queue_pkg;

  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // FIFO entry layout: {op[11:10], c[9:8], b[7:4], a[3:0]}
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] c;
    logic [3:0] b;
    logic [3:0] a;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic [1:0] op, input logic [1:0] c,
                                    input logic [3:0] b,  input logic [3:0] a);
    cmd_t w_cmd;
    w_cmd.op = op;
    w_cmd.c  = c;
    w_cmd.b  = b;
    w_cmd.a  = a;
    return w_cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu2_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : alu2_cmd_fifo
// Purpose : DEPTH-entry synchronous command FIFO with full/empty/count status
// Rev     : 1.0  initial release
// ============================================================================
module alu2_cmd_fifo
  import alu2_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  cmd_t                       i_data,
  input  logic                       i_pop,
  output cmd_t                       o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] c_DEPTH   = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] c_CNT_ONE = CNT_BITS'(1);
  localparam logic [PTR_W-1:0]    c_PTR_ONE = PTR_W'(1);

  cmd_t                r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_count == c_DEPTH);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/alu2_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : alu2_issue_queue
// Purpose : Buffers ALU2 commands, issues one at a time, registers the answer
// Rev     : 1.0  initial release
// ============================================================================
module alu2_issue_queue
  import alu2_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_c,
  output logic [3:0]       alu_inA,
  output logic [3:0]       alu_inB,
  output logic [1:0]       alu_inC,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_ans,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [1:0]       res_op,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [CNT_W-1:0] c_DONE_ONE = CNT_W'(1);

  state_t                 r_state;
  state_t                 w_next;
  cmd_t                   w_wdata;
  cmd_t                   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [$clog2(DEPTH):0] w_count;

  assign w_wdata   = pack_cmd(cmd_op, cmd_c, cmd_b, cmd_a);
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ISSUE);

  alu2_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    alu_inA = '0;
    alu_inB = '0;
    alu_inC = '0;
    alu_op  = '0;
    case (r_state)
      IDLE: begin
        if (w_count != '0) w_next = ISSUE;
      end
      ISSUE: begin
        alu_inA = w_head.a;
        alu_inB = w_head.b;
        alu_inC = w_head.c;
        alu_op  = w_head.op;
        w_next  = HOLD;
      end
      HOLD: begin
        // A push landing on this same edge counts toward the next issue
        if (res_ready) w_next = (!w_empty || w_push) ? ISSUE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      done_cnt  <= '0;
    end else if (r_state == ISSUE) begin
      res_valid <= 1'b1;
      res_data  <= alu_ans;
      res_op    <= w_head.op;
    end else if ((r_state == HOLD) && res_ready) begin
      res_valid <= 1'b0;
      done_cnt  <= done_cnt + c_DONE_ONE;
    end
  end

endmodule
`default_nettype wire
